// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL supervisor in the reference-clock domain.
// Holds the PLL in reset, waits for a qualified lock, then releases the system
// reset. The PLL is restarted when lock is lost in RUN or never arrives.
// Repeated lock timeouts end in a sticky FAULT state.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       pll_ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    // The cycle counter must hold the largest terminal count of any state.
    localparam int MAX_RS = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_P  = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [3:0]    retry_cnt_q, retry_cnt_d;
    logic [7:0]    lock_loss_cnt_q, lock_loss_cnt_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          pll_ready_q, pll_ready_d;
    logic          fault_q, fault_d;
    logic          lock_meta_q, lock_s_q;

    // Two-flop synchroniser for the asynchronous PLL lock pin.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, counters and registered outputs derived from the next state.
    always_comb begin
        state_d         = state_q;
        cyc_cnt_d       = cyc_cnt_q + 1'b1;
        retry_cnt_d     = retry_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;

        case (state_q)
            RESET_PLL: begin
                if (cyc_cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins.
                if (lock_s_q) begin
                    state_d = STABLE;
                end else if (cyc_cnt_q == TIMEOUT_LAST) begin
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    state_d     = (retry_cnt_d == RETRY_LIMIT) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                // Any dropout restarts the lock wait without counting a retry.
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cyc_cnt_q == STABLE_LAST) begin
                    state_d     = RUN;
                    retry_cnt_d = 4'd0;
                end
            end
            RUN: begin
                cyc_cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = RESET_PLL;
                    if (lock_loss_cnt_q != 8'hFF) begin
                        lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
                    end
                end
            end
            FAULT: begin
                cyc_cnt_d = '0;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) begin
            cyc_cnt_d = '0;
        end

        pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
        sys_rst_d   = (state_d != RUN);
        pll_ready_d = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    // State, counters and output registers.
    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state_q         <= RESET_PLL;
            cyc_cnt_q       <= '0;
            retry_cnt_q     <= 4'd0;
            lock_loss_cnt_q <= 8'd0;
            pll_rst_q       <= 1'b1;
            sys_rst_q       <= 1'b1;
            pll_ready_q     <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cyc_cnt_q       <= cyc_cnt_d;
            retry_cnt_q     <= retry_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
            pll_rst_q       <= pll_rst_d;
            sys_rst_q       <= sys_rst_d;
            pll_ready_q     <= pll_ready_d;
            fault_q         <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign pll_ready     = pll_ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Testbench for pll_lock_ctrl: stimulus pushes the expected output vector and
// the cycle it should appear in; a monitor pops an entry whenever the DUT
// outputs change and compares value and timing.
module tb_pll_lock_ctrl;

    logic       clkin1 = 1'b0;
    logic       rst    = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_rst, sys_rst, pll_ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    pll_lock_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (3)
    ) dut (
        .clkin1       (clkin1),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .pll_ready    (pll_ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clkin1 = ~clkin1;

    int cyc = 0;
    always @(posedge clkin1) cyc <= cyc + 1;

    typedef struct packed {
        logic signed [31:0] at_cyc;   // -1: timing not checked
        logic [7:0]         tag;
        logic [15:0]        vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic logic [15:0] mk(input logic p, input logic s, input logic r,
                                       input logic f, input logic [3:0] rc,
                                       input logic [7:0] lc);
        return {p, s, r, f, rc, lc};
    endfunction

    function automatic void push(input int c, input int tag, input logic [15:0] v);
        exp_t e;
        e.at_cyc = c;
        e.tag    = 8'(tag);
        e.vec    = v;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clkin1);
        #1;
    endtask

    // Monitor: every change of the output vector consumes one expectation.
    logic [15:0] prev_vec = 'x;
    always @(negedge clkin1) begin
        logic [15:0] cur;
        exp_t        e;
        cur = {pll_rst, sys_rst, pll_ready, fault, retry_cnt, lock_loss_cnt};
        if (cur !== prev_vec) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_change @cyc %0d: got %h, want no change", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e.vec || (e.at_cyc >= 0 && e.at_cyc != cyc)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL test%0d @cyc %0d: got %h, want %h @cyc %0d",
                             e.tag, cyc, cur, e.vec, e.at_cyc);
                end else begin
                    $display("ok   test%0d @cyc %0d vec %h", e.tag, cyc, cur);
                end
            end
            prev_vec = cur;
        end
    end

    // One-cycle lock dropout while in RUN, then recovery back to RUN.
    task automatic drop_in_run(input int tag, input logic [7:0] loss);
        int d;
        d = cyc;
        push(d + 3,  tag, mk(1, 1, 0, 0, 4'd0, loss));
        push(d + 7,  tag, mk(0, 1, 0, 0, 4'd0, loss));
        push(d + 16, tag, mk(0, 0, 1, 0, 4'd0, loss));
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(18);
    endtask

    initial begin
        int t0, l, b, c;
        // Reset state
        push(-1, 0, mk(1, 1, 0, 0, 4'd0, 8'd0));
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        t0 = cyc;
        push(t0 + 4, 1, mk(0, 1, 0, 0, 4'd0, 8'd0));

        // 1: lock 10 cycles after release -> RUN 2+8+1 cycles later
        tick(10);
        l = cyc;
        pll_lock = 1'b1;
        push(l + 11, 1, mk(0, 0, 1, 0, 4'd0, 8'd0));
        tick(15);

        // 3: single-cycle dropout in RUN
        drop_in_run(3, 8'd1);

        // 5: 300 more dropouts, counter saturates at 255
        for (int k = 2; k <= 301; k++) begin
            drop_in_run(5, (k > 255) ? 8'd255 : 8'(k));
        end

        // 6a: asynchronous reset in RUN
        push(cyc, 6, mk(1, 1, 0, 0, 4'd0, 8'd0));
        rst = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        rst = 1'b0;
        t0 = cyc;
        push(t0 + 4, 6, mk(0, 1, 0, 0, 4'd0, 8'd0));
        tick(6);

        // 4: lock toggles every 5 cycles -> no RUN, no retry until a full window
        b = 0;
        for (int m = 0; m < 6; m++) begin
            pll_lock = 1'b1;
            tick(5);
            pll_lock = 1'b0;
            b = cyc;
            tick(5);
        end
        push(b + 23, 4, mk(1, 1, 0, 0, 4'd1, 8'd0));
        push(b + 27, 4, mk(0, 1, 0, 0, 4'd1, 8'd0));
        tick(25);

        // 6b: asynchronous reset in STABLE
        c = cyc;
        pll_lock = 1'b1;
        tick(6);
        push(c + 6, 6, mk(1, 1, 0, 0, 4'd0, 8'd0));
        rst = 1'b1;
        pll_lock = 1'b0;
        tick(2);
        rst = 1'b0;
        t0 = cyc;
        push(t0 + 4, 6, mk(0, 1, 0, 0, 4'd0, 8'd0));

        // 2: lock never arrives -> three timeouts, then sticky FAULT
        push(t0 + 24, 2, mk(1, 1, 0, 0, 4'd1, 8'd0));
        push(t0 + 28, 2, mk(0, 1, 0, 0, 4'd1, 8'd0));
        push(t0 + 48, 2, mk(1, 1, 0, 0, 4'd2, 8'd0));
        push(t0 + 52, 2, mk(0, 1, 0, 0, 4'd2, 8'd0));
        push(t0 + 72, 2, mk(1, 1, 0, 1, 4'd3, 8'd0));
        tick(80);
        pll_lock = 1'b1;   // lock arriving in FAULT must change nothing
        tick(200);

        // Every expectation must have been consumed
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL test%0d missing_change: got no change, want %h @cyc %0d",
                     e.tag, e.vec, e.at_cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
